bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Two-requester arbiter that shares a single port of the dual-port BRAM (one-cycle registered read, no write-through) between requesters, e.g. core data access and a loader/DMA. It sits between the requesters and the BRAM's en/we/addr/di/do port. It performs round-robin arbitration and routes the one-cycle-later read response back to the originating requester. A lock qualifier lets one requester hold the port for an atomic read-modify-write sequence (RV32A AMO/LR-SC).

## Interface
- WADDR, 10, BRAM address width
- WDATA, 32, data width
- pi_clk  in  1  clock; shared with the BRAM port
- pi_rst  in  1  asynchronous, active-high reset
- pi_req_valid_0 / pi_req_valid_1  in  1  request valid
- po_req_ready_0 / po_req_ready_1  out  1  request accepted this cycle when valid&&ready
- pi_req_we_0 / pi_req_we_1  in  1  1=write, 0=read
- pi_req_lock_0 / pi_req_lock_1  in  1  keep grant after this request
- pi_req_addr_0 / pi_req_addr_1  in  WADDR  word address
- pi_req_wdata_0 / pi_req_wdata_1  in  WDATA  write data
- po_rsp_valid_0 / po_rsp_valid_1  out  1  read data valid, single-cycle pulse
- po_rsp_rdata_0 / po_rsp_rdata_1  out  WDATA  read data
- po_en, po_we  out  1  BRAM enable / write enable
- po_addr  out  WADDR  BRAM address
- po_di  out  WDATA  BRAM write data
- pi_do  in  WDATA  BRAM read data (registered inside BRAM)

## Operation
- At most one request is accepted per cycle. The grant is one-hot and computed combinationally from the valid inputs, the state, and the priority pointer.
- po_req_ready_r equals grant_r. Ready may depend on valid; valid must not depend on ready.
- BRAM drive:
  - po_en = accepted.
  - po_we, po_addr, po_di are muxed from the granted requester.
  - With no grant, all BRAM outputs are 0.
- FSM arb_state: ARB_FREE, ARB_LOCK0, ARB_LOCK1.
  - ARB_FREE:
    - If both requesters are valid, grant the one named by prio.
    - If only one is valid, grant that one.
    - Accepting a request from r with lock=1 moves to ARB_LOCKr.
    - Accepting a request from r with lock=0 sets prio to the other requester.
  - ARB_LOCKr:
    - Only r can be granted; the other requester's ready is 0 even when r is idle.
    - Accepting a request from r with lock=0 returns to ARB_FREE and sets prio to the other requester.
    - Accepting a request from r with lock=1 stays in ARB_LOCKr.
- The pointer prio is 1 bit.
- Response routing:
  - A registered tag {rd_pend, rd_src} is set when a read (we=0) is accepted.
  - In the next cycle, po_rsp_valid_<rd_src> = 1 and po_rsp_rdata_<rd_src> = pi_do.
  - The non-selected po_rsp_rdata output is 0.
  - Writes produce no response.
- There is no response backpressure. Requesters must sink the response in the cycle it appears.

## Timing
- Reset values, applied asynchronously:
  - arb_state = ARB_FREE, prio = 0, rd_pend = 0, rd_src = 0.
  - While pi_rst is high, every ready, po_en and po_rsp_valid output is 0.
- Read latency: accepted in cycle T, response in T+1. Back-to-back reads issue one per cycle, from either or alternating requesters, with no bubble.
- Write: the BRAM is updated at the end of cycle T. A read of the same address accepted in T+1 returns the new data in T+2.
- Simultaneous events:
  - A new request is accepted in the same cycle a previous read response is delivered.
  - The tag register updates from the new acceptance.
- Reset mid-lock: returns to ARB_FREE and drops any pending response (no pulse after reset deasserts).
- A lock request whose requester deasserts valid keeps the lock indefinitely. Releasing the lock is the requester's responsibility.

## Structure
- Package bram_arb_pkg:
  - typedef enum arb_state_t {ARB_FREE, ARB_LOCK0, ARB_LOCK1}
  - localparam NREQ = 2
  - typedef req_id_t (1 bit)
- Sub-module bram_arb_grant: purely combinational. Inputs are valid[1:0], arb_state and prio; output is grant[1:0]. It is instantiated once.
- All registers live in bram_port_arbiter.

## Test plan
- Single read: after reset, requester 0 reads addr 0x005 holding 0xDEADBEEF. Required: ready_0=1 in T, po_en=1, po_addr=0x005 in T, po_rsp_valid_0=1 with rdata 0xDEADBEEF in T+1, po_rsp_valid_1=0.
- Contention: both requesters are valid with reads every cycle for 6 cycles. Required: grants alternate 0,1,0,1,0,1 and each response returns to the correct requester.
- Lock/AMO:
  - Requester 1 reads 0x010 with lock=1, then writes 0x010 = 0x00000007 with lock=0, while requester 0 is continuously valid.
  - Required: ready_0=0 during both cycles, then requester 0 is granted next.
  - A subsequent read of 0x010 returns 0x00000007.
- Write/read hazard: requester 0 writes 0x3FF = 0x12345678 in T and reads 0x3FF in T+1. Required: rdata 0x12345678 in T+2.
- Reset mid-operation: assert pi_rst in ARB_LOCK0 with a read pending. Required: outputs go to 0 immediately, no rsp_valid after release, and prio=0 on the first contended cycle.
- Idle: no valid inputs for 10 cycles. Required: po_en=0 and no rsp_valid throughout.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the two-requester BRAM port arbiter.
package bram_arb_pkg;
  typedef enum logic [1:0] {ARB_FREE, ARB_LOCK0, ARB_LOCK1} arb_state_t;
  localparam int NREQ = 2;
  typedef logic req_id_t;
endpackage

// File: rtl/bram_port_arbiter_if.sv
// Request/response and BRAM-port bundle; master = requesters + BRAM, slave = arbiter.
interface bram_port_arbiter_if #(
  parameter int WADDR = 10,
  parameter int WDATA = 32
);
  logic             pi_req_valid_0, pi_req_valid_1;
  logic             po_req_ready_0, po_req_ready_1;
  logic             pi_req_we_0,    pi_req_we_1;
  logic             pi_req_lock_0,  pi_req_lock_1;
  logic [WADDR-1:0] pi_req_addr_0,  pi_req_addr_1;
  logic [WDATA-1:0] pi_req_wdata_0, pi_req_wdata_1;
  logic             po_rsp_valid_0, po_rsp_valid_1;
  logic [WDATA-1:0] po_rsp_rdata_0, po_rsp_rdata_1;
  logic             po_en, po_we;
  logic [WADDR-1:0] po_addr;
  logic [WDATA-1:0] po_di;
  logic [WDATA-1:0] pi_do;

  modport master (
    output pi_req_valid_0, pi_req_valid_1, pi_req_we_0, pi_req_we_1,
           pi_req_lock_0, pi_req_lock_1, pi_req_addr_0, pi_req_addr_1,
           pi_req_wdata_0, pi_req_wdata_1, pi_do,
    input  po_req_ready_0, po_req_ready_1, po_rsp_valid_0, po_rsp_valid_1,
           po_rsp_rdata_0, po_rsp_rdata_1, po_en, po_we, po_addr, po_di
  );

  modport slave (
    input  pi_req_valid_0, pi_req_valid_1, pi_req_we_0, pi_req_we_1,
           pi_req_lock_0, pi_req_lock_1, pi_req_addr_0, pi_req_addr_1,
           pi_req_wdata_0, pi_req_wdata_1, pi_do,
    output po_req_ready_0, po_req_ready_1, po_rsp_valid_0, po_rsp_valid_1,
           po_rsp_rdata_0, po_rsp_rdata_1, po_en, po_we, po_addr, po_di
  );
endinterface

// File: rtl/bram_arb_grant.sv
// Combinational one-hot grant: round-robin when free, owner-only when locked.
module bram_arb_grant
  import bram_arb_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  arb_state_t      arb_state,
  input  req_id_t         prio,
  output logic [NREQ-1:0] grant
);
  always_comb begin
    grant = '0;
    case (arb_state)
      ARB_FREE: begin
        if (&valid) grant[prio] = 1'b1;
        else        grant = valid;
      end
      ARB_LOCK0: grant[0] = valid[0];
      ARB_LOCK1: grant[1] = valid[1];
      default:   grant = '0;
    endcase
  end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two requesters with round-robin, lock for
// atomic RMW, and routing of the one-cycle-late read data to its requester.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int WADDR = 10,
  parameter int WDATA = 32
) (
  input logic pi_clk,
  input logic pi_rst,
  bram_port_arbiter_if.slave bus
);
  arb_state_t      arb_state, arb_state_n;
  req_id_t         prio, prio_n;
  logic            rd_pend, rd_pend_n;
  req_id_t         rd_src, rd_src_n;
  logic [NREQ-1:0] valid, grant_raw, gnt;
  logic            acc, lock, we;
  req_id_t         src;

  assign valid = {bus.pi_req_valid_1, bus.pi_req_valid_0};

  bram_arb_grant u_grant (
    .valid     (valid),
    .arb_state (arb_state),
    .prio      (prio),
    .grant     (grant_raw)
  );

  // Reset is async but grant is combinational: mask it so nothing leaks out during reset.
  assign gnt  = grant_raw & {NREQ{~pi_rst}};
  assign acc  = |gnt;
  assign src  = gnt[1];
  assign lock = src ? bus.pi_req_lock_1 : bus.pi_req_lock_0;
  assign we   = src ? bus.pi_req_we_1   : bus.pi_req_we_0;

  assign bus.po_req_ready_0 = gnt[0];
  assign bus.po_req_ready_1 = gnt[1];

  assign bus.po_en   = acc;
  assign bus.po_we   = acc & we;
  assign bus.po_addr = gnt[1] ? bus.pi_req_addr_1  : gnt[0] ? bus.pi_req_addr_0  : '0;
  assign bus.po_di   = gnt[1] ? bus.pi_req_wdata_1 : gnt[0] ? bus.pi_req_wdata_0 : '0;

  assign bus.po_rsp_valid_0 = rd_pend & ~rd_src;
  assign bus.po_rsp_valid_1 = rd_pend &  rd_src;
  assign bus.po_rsp_rdata_0 = bus.po_rsp_valid_0 ? bus.pi_do : '0;
  assign bus.po_rsp_rdata_1 = bus.po_rsp_valid_1 ? bus.pi_do : '0;

  always_comb begin
    arb_state_n = arb_state;
    prio_n      = prio;
    rd_pend_n   = acc & ~we;
    rd_src_n    = acc ? src : rd_src;
    case (arb_state)
      ARB_FREE: begin
        if (acc) begin
          if (lock) arb_state_n = src ? ARB_LOCK1 : ARB_LOCK0;
          else      prio_n      = ~src;
        end
      end
      ARB_LOCK0, ARB_LOCK1: begin
        // Only the owner can be granted here, so src is the lock holder.
        if (acc && !lock) begin
          arb_state_n = ARB_FREE;
          prio_n      = ~src;
        end
      end
      default: arb_state_n = ARB_FREE;
    endcase
  end

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      arb_state <= ARB_FREE;
      prio      <= 1'b0;
      rd_pend   <= 1'b0;
      rd_src    <= 1'b0;
    end else begin
      arb_state <= arb_state_n;
      prio      <= prio_n;
      rd_pend   <= rd_pend_n;
      rd_src    <= rd_src_n;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Vector table for grants/BRAM drive plus a response scoreboard against a shadow memory.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;
  localparam int WADDR = 10;
  localparam int WDATA = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram_port_arbiter_if #(.WADDR(WADDR), .WDATA(WDATA)) bus ();

  bram_port_arbiter #(.WADDR(WADDR), .WDATA(WDATA)) dut (
    .pi_clk (clk),
    .pi_rst (rst),
    .bus    (bus)
  );

  function automatic logic [31:0] init_word(int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(i));
  endfunction

  // Read-first BRAM model, no write-through.
  logic [31:0] bram [0:1023];
  logic [31:0] bram_do;
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) bram[i] <= init_word(i);
      bram_do <= '0;
    end else if (bus.po_en) begin
      if (bus.po_we) bram[bus.po_addr] <= bus.po_di;
      bram_do <= bram[bus.po_addr];
    end
  end
  assign bus.pi_do = bram_do;

  typedef struct {
    logic v0, v1, l0, l1, w0, w1;
    logic [WADDR-1:0] a0, a1;
    logic [WDATA-1:0] d0, d1;
    logic [1:0] eg;
  } vec_t;

  typedef struct {
    logic        src;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] ref_mem [0:1023];
  rsp_t sb[$];
  vec_t vt[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic vec_t mk(logic v0, logic v1, logic l0, logic l1, logic w0, logic w1,
                              logic [WADDR-1:0] a0, logic [WADDR-1:0] a1,
                              logic [WDATA-1:0] d0, logic [WDATA-1:0] d1, logic [1:0] eg);
    vec_t v;
    v.v0 = v0; v.v1 = v1; v.l0 = l0; v.l1 = l1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.eg = eg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.pi_req_valid_0 = v.v0; bus.pi_req_valid_1 = v.v1;
    bus.pi_req_lock_0  = v.l0; bus.pi_req_lock_1  = v.l1;
    bus.pi_req_we_0    = v.w0; bus.pi_req_we_1    = v.w1;
    bus.pi_req_addr_0  = v.a0; bus.pi_req_addr_1  = v.a1;
    bus.pi_req_wdata_0 = v.d0; bus.pi_req_wdata_1 = v.d1;
  endtask

  // One cycle: drive, check response and request side at negedge, score the accept.
  task automatic step(input vec_t v, input string tag);
    rsp_t e;
    logic s, w;
    logic [WADDR-1:0] a;
    logic [WDATA-1:0] d;
    drive(v);
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rv0"}, 32'(bus.po_rsp_valid_0), 32'(e.src == 1'b0));
      chk({tag, "_rv1"}, 32'(bus.po_rsp_valid_1), 32'(e.src == 1'b1));
      chk({tag, "_rd0"}, bus.po_rsp_rdata_0, e.src ? 32'h0 : e.data);
      chk({tag, "_rd1"}, bus.po_rsp_rdata_1, e.src ? e.data : 32'h0);
    end else begin
      chk({tag, "_rv0"}, 32'(bus.po_rsp_valid_0), 32'h0);
      chk({tag, "_rv1"}, 32'(bus.po_rsp_valid_1), 32'h0);
    end
    s = v.eg[1];
    w = s ? v.w1 : v.w0;
    a = (v.eg == 2'b00) ? '0 : (s ? v.a1 : v.a0);
    d = (v.eg == 2'b00) ? '0 : (s ? v.d1 : v.d0);
    chk({tag, "_rdy"},  32'({bus.po_req_ready_1, bus.po_req_ready_0}), 32'(v.eg));
    chk({tag, "_en"},   32'(bus.po_en), 32'(|v.eg));
    chk({tag, "_addr"}, 32'(bus.po_addr), 32'(a));
    chk({tag, "_we"},   32'(bus.po_we), 32'((|v.eg) & w));
    if (|v.eg && w) chk({tag, "_di"}, bus.po_di, d);
    if (|v.eg) begin
      if (!w) sb.push_back('{src: s, data: ref_mem[a]});
      else    ref_mem[a] = d;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    drive(mk(1, 1, 0, 0, 0, 0, 10'h1, 10'h2, 0, 0, 2'b00));
    #2;
    chk("rst_rdy", 32'({bus.po_req_ready_1, bus.po_req_ready_0}), 32'h0);
    chk("rst_en",  32'(bus.po_en), 32'h0);
    chk("rst_rv",  32'({bus.po_rsp_valid_1, bus.po_rsp_valid_0}), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    @(posedge clk);
    #1;

    vt.push_back(mk(1, 0, 0, 0, 0, 0, 10'h005, 0, 0, 0, 2'b01));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 10'h007, 0, 0, 2'b10));
    for (int i = 0; i < 6; i++)
      vt.push_back(mk(1, 1, 0, 0, 0, 0, 10'(10'h020 + i), 10'(10'h040 + i), 0, 0,
                      (i % 2 == 0) ? 2'b01 : 2'b10));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 10'h011, 0, 0, 0, 2'b01));
    vt.push_back(mk(1, 1, 0, 1, 0, 0, 10'h030, 10'h010, 0, 0, 2'b10));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 10'h030, 0, 0, 0, 2'b00));
    vt.push_back(mk(1, 1, 0, 0, 0, 1, 10'h030, 10'h010, 0, 32'h7, 2'b10));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 10'h030, 0, 0, 0, 2'b01));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 10'h010, 0, 0, 0, 2'b01));
    vt.push_back(mk(1, 0, 0, 0, 1, 0, 10'h3FF, 0, 32'h12345678, 0, 2'b01));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 10'h3FF, 0, 0, 0, 2'b01));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    vt.push_back(mk(1, 0, 1, 0, 0, 0, 10'h012, 0, 0, 0, 2'b01));
    vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 10'h013, 0, 0, 2'b00));
    vt.push_back(mk(1, 1, 1, 0, 0, 0, 10'h014, 10'h015, 0, 0, 2'b01));
    for (int i = 0; i < vt.size(); i++) step(vt[i], $sformatf("v%0d", i));

    // Reset while locked to requester 0 with a read response due.
    drive(mk(1, 1, 0, 0, 0, 0, 10'h050, 10'h060, 0, 0, 2'b00));
    rst = 1'b1;
    #1;
    chk("mid_rdy", 32'({bus.po_req_ready_1, bus.po_req_ready_0}), 32'h0);
    chk("mid_en",  32'(bus.po_en), 32'h0);
    chk("mid_rv",  32'({bus.po_rsp_valid_1, bus.po_rsp_valid_0}), 32'h0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    @(posedge clk);
    #1;
    step(mk(1, 1, 0, 0, 0, 0, 10'h050, 10'h060, 0, 0, 2'b01), "post0");
    step(mk(1, 1, 0, 0, 0, 0, 10'h051, 10'h061, 0, 0, 2'b10), "post1");
    for (int i = 0; i < 11; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00), $sformatf("idle%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
